// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and
// the width of the bit counter.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // $clog2 of 1 is 0; the counter always keeps at least one bit.
  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_adder_full_adder_bit.sv
// One-bit combinational full-adder cell, reused every cycle by serial_adder.
module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// WIDTH-bit serial adder: one full-adder cell, LSB first, start/busy/done handshake.
// Define SERIAL_ADDER_OVF_EN to add a registered signed-overflow output.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] addend,
  input  logic [WIDTH-1:0] augend,
  input  logic             carry_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             overflow
`endif
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] s_sr_q, s_sr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_out_q, carry_out_d;
`ifdef SERIAL_ADDER_OVF_EN
  logic             overflow_q, overflow_d;
`endif

  logic             fa_s;
  logic             fa_c;
  logic [WIDTH-1:0] s_sr_next;

  full_adder_bit u_fa (
    .a    (a_sr_q[0]),
    .b    (b_sr_q[0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_c)
  );

  // New sum bit enters at the MSB so the LSB-first result lands in order.
  assign s_sr_next = (s_sr_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));

  always_comb begin
    state_d     = state_q;
    a_sr_d      = a_sr_q;
    b_sr_d      = b_sr_q;
    s_sr_d      = s_sr_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    sum_d       = sum_q;
    carry_out_d = carry_out_q;
`ifdef SERIAL_ADDER_OVF_EN
    overflow_d  = overflow_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          a_sr_d  = addend;
          b_sr_d  = augend;
          carry_d = carry_in;
          cnt_d   = '0;
        end
      end
      RUN: begin
        a_sr_d  = a_sr_q >> 1;
        b_sr_d  = b_sr_q >> 1;
        s_sr_d  = s_sr_next;
        carry_d = fa_c;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d     = DONE;
          sum_d       = s_sr_next;
          carry_out_d = fa_c;
`ifdef SERIAL_ADDER_OVF_EN
          // carry into the MSB is the carry flop while the MSB is processed
          overflow_d  = carry_q ^ fa_c;
`endif
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= IDLE;
      a_sr_q      <= '0;
      b_sr_q      <= '0;
      s_sr_q      <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      sum_q       <= '0;
      carry_out_q <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      overflow_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      a_sr_q      <= a_sr_d;
      b_sr_q      <= b_sr_d;
      s_sr_q      <= s_sr_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      sum_q       <= sum_d;
      carry_out_q <= carry_out_d;
`ifdef SERIAL_ADDER_OVF_EN
      overflow_q  <= overflow_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign sum       = sum_q;
  assign carry_out = carry_out_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign overflow  = overflow_q;
`endif

endmodule
